fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, 8'd255, maximum wait cycles for an imem ack before trapping.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 o_imem_req  output  1  instruction-memory read request.
REQ-006 o_imem_addr  output  32  word address of the request; equals o_pc.
REQ-007 i_imem_ack  input  1  one-cycle pulse; i_imem_rdata is valid in that cycle.
REQ-008 i_imem_rdata  input  32  fetched instruction word.
REQ-009 o_instr  output  32  latched instruction presented to decode/control.
REQ-010 o_instr_valid  output  1  o_instr and o_pc are stable and valid.
REQ-011 o_pc / o_pc_four  output  32 each  PC of o_instr, and o_pc+4 (modulo 2^32).
REQ-012 i_inst_valid  input  1  decoder's legal-opcode flag for o_instr.
REQ-013 i_pc_sel  input  1  1 = next PC is the jump target, 0 = PC+4.
REQ-014 i_jmp_target  input  32  branch/jump target from ALU.
REQ-015 i_retire  input  1  execute has completed the current instruction.
REQ-016 o_trap / o_trap_cause  output  1 / 2  sticky trap flag; cause 01 misaligned, 10 timeout, 11 illegal.
REQ-017 o_instret  output  32  retired-instruction counter.

Function
REQ-018 FSM states SHALL be BOOT, FETCH, ISSUE and TRAP.
REQ-019 BOOT SHALL last one cycle and then go to FETCH.
REQ-020 o_imem_req SHALL be 1 exactly while in FETCH (decoded from state).
REQ-021 FETCH SHALL hold o_imem_addr=o_pc constant until ack.
REQ-022 FETCH SHALL increment a wait counter each cycle without ack.
REQ-023 FETCH on i_imem_ack SHALL latch o_instr<=i_imem_rdata, clear the wait counter and go to ISSUE.
REQ-024 Latency: ack in cycle N gives o_instr_valid=1 in cycle N+1.
REQ-025 FETCH SHALL go to TRAP with cause 10 when the wait counter reaches TIMEOUT with no ack; an ack in that same cycle takes priority over the timeout.
REQ-026 ISSUE SHALL assert o_instr_valid and hold o_instr and o_pc until i_retire=1.
REQ-027 On i_retire in ISSUE with i_inst_valid=0: go to TRAP with cause 11; PC unchanged; o_instret unchanged.
REQ-028 On i_retire in ISSUE with i_inst_valid=1, the next PC SHALL be i_pc_sel ? {i_jmp_target[31:1],1'b0} : o_pc+4.
REQ-029 If that next PC has bit 1 set: go to TRAP with cause 01; PC unchanged; o_instret unchanged.
REQ-030 Otherwise, on a valid retire: load the next PC, increment o_instret, go to FETCH; o_imem_req=1 with the new address in cycle M+1 for retire in cycle M.
REQ-031 o_instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-032 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 = 0 with no trap.
REQ-033 i_imem_ack outside FETCH and i_retire outside ISSUE SHALL be ignored.
REQ-034 i_pc_sel and i_jmp_target SHALL be sampled only in the retire cycle.
REQ-035 TRAP SHALL be absorbing: o_trap=1, cause held, o_imem_req=0, o_instr_valid=0, until reset.

Reset
REQ-036 i_reset SHALL take effect immediately, with no clock edge, including mid-fetch; o_imem_req drops during reset.
REQ-037 Reset values: state BOOT, o_pc=RESET_PC, o_pc_four=RESET_PC+4, o_instr=32'h0000_0013 (nop), o_instr_valid=0, o_imem_req=0, o_trap=0, o_trap_cause=00, o_instret=0, wait counter=0.

Verification
REQ-038 Reset release; ack 2 cycles after req with rdata 32'h00500093 -> req at addr 0 in cycle 2; o_instr=32'h00500093 and valid one cycle after ack.
REQ-039 Retire with i_pc_sel=0, then retire with i_pc_sel=1 and i_jmp_target=32'h0000_0101 -> addresses 0, 4, then 32'h100; o_instret=2.
REQ-040 i_jmp_target=32'h0000_0106 with i_pc_sel=1 at retire -> o_trap=1, cause 01, o_pc unchanged, no further req.
REQ-041 Hold i_imem_ack=0 for TIMEOUT cycles -> trap cause 10; repeat with ack on the final cycle -> no trap, ISSUE entered.
REQ-042 Retire with i_inst_valid=0 -> trap cause 11, o_instret unchanged.
REQ-043 Assert i_reset mid-FETCH and mid-TRAP -> outputs at reset values immediately; after release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, decode/execute sideband and status.
// master = fetch unit, slave = memory/decode/execute environment.
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc_four;
    logic        i_inst_valid;
    logic        i_pc_sel;
    logic [31:0] i_jmp_target;
    logic        i_retire;
    logic        o_trap;
    logic [1:0]  o_trap_cause;
    logic [31:0] o_instret;

    modport master (
        output o_imem_req, o_imem_addr, o_instr, o_instr_valid, o_pc, o_pc_four,
               o_trap, o_trap_cause, o_instret,
        input  i_imem_ack, i_imem_rdata, i_inst_valid, i_pc_sel, i_jmp_target, i_retire
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_instr, o_instr_valid, o_pc, o_pc_four,
               o_trap, o_trap_cause, o_instret,
        output i_imem_ack, i_imem_rdata, i_inst_valid, i_pc_sel, i_jmp_target, i_retire
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer BOOT -> FETCH -> ISSUE with sticky TRAP; o_instr valid the cycle after ack,
// next request the cycle after retire; holds request until ack (bounded by TIMEOUT) and instruction until retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input logic          i_clk,
    input logic          i_reset,
    fetch_unit_if.master bus
);
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
    logic [7:0]  wait_cnt;
    logic [1:0]  cause;
    logic [31:0] next_pc;
    logic        timeout_hit;

    always_comb begin
        next_pc     = bus.i_pc_sel ? (bus.i_jmp_target & ~32'd1) : pc + 32'd4;
        // true on the TIMEOUT-th consecutive cycle without ack
        timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            instr    <= NOP;
            instret  <= '0;
            wait_cnt <= '0;
            cause    <= 2'b00;
        end else begin
            case (state)
                ST_BOOT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.i_imem_ack) begin
                        instr    <= bus.i_imem_rdata;
                        wait_cnt <= '0;
                        state    <= ST_ISSUE;
                    end else if (timeout_hit) begin
                        cause <= CAUSE_TIMEOUT;
                        state <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.i_retire) begin
                        if (!bus.i_inst_valid) begin
                            cause <= CAUSE_ILLEGAL;
                            state <= ST_TRAP;
                        end else if (next_pc[1]) begin
                            cause <= CAUSE_MISALIGN;
                            state <= ST_TRAP;
                        end else begin
                            pc      <= next_pc;
                            instret <= instret + 32'd1;
                            state   <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_TRAP;
            endcase
        end
    end

    assign bus.o_imem_req    = (state == ST_FETCH);
    assign bus.o_imem_addr   = pc;
    assign bus.o_instr       = instr;
    assign bus.o_instr_valid = (state == ST_ISSUE);
    assign bus.o_pc          = pc;
    assign bus.o_pc_four     = pc + 32'd4;
    assign bus.o_trap        = (state == ST_TRAP);
    assign bus.o_trap_cause  = cause;
    assign bus.o_instret     = instret;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: driver pushes expected req/issue/trap events from a PC/instret model,
// a negedge monitor pops and compares them as the DUT raises each output.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [7:0]  TIMEOUT  = 8'd255;
    localparam int          T_OUT    = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_REQ, EV_ISSUE, EV_TRAP} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] instret;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_instret;
    bit          m_trap;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic void expect_ev(input ev_kind_t k, input logic [1:0] c);
        exp_t e;
        e.kind = k; e.pc = m_pc; e.instr = m_instr; e.instret = m_instret; e.cause = c;
        sb.push_back(e);
    endfunction

    task automatic mon_event(input ev_kind_t k);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", 1'b0,
                  $sformatf("got %s at pc=%h, expected no event", k.name(), bus.o_pc));
            return;
        end
        e = sb.pop_front();
        if (e.kind != k) begin
            check("event_order", 1'b0, $sformatf("got %s pc=%h, expected %s pc=%h",
                  k.name(), bus.o_pc, e.kind.name(), e.pc));
            return;
        end
        case (k)
            EV_REQ: check("req_addr", bus.o_imem_addr == e.pc,
                          $sformatf("addr=%h, expected %h", bus.o_imem_addr, e.pc));
            EV_ISSUE: check("issue",
                          bus.o_pc == e.pc && bus.o_pc_four == e.pc + 32'd4 &&
                          bus.o_instr == e.instr && bus.o_instret == e.instret,
                          $sformatf("pc=%h pc4=%h instr=%h instret=%0d, expected %h %h %h %0d",
                                    bus.o_pc, bus.o_pc_four, bus.o_instr, bus.o_instret,
                                    e.pc, e.pc + 32'd4, e.instr, e.instret));
            default: check("trap",
                          bus.o_trap_cause == e.cause && bus.o_pc == e.pc &&
                          bus.o_instret == e.instret && !bus.o_imem_req && !bus.o_instr_valid,
                          $sformatf("cause=%b pc=%h instret=%0d req=%b vld=%b, expected %b %h %0d 0 0",
                                    bus.o_trap_cause, bus.o_pc, bus.o_instret, bus.o_imem_req,
                                    bus.o_instr_valid, e.cause, e.pc, e.instret));
        endcase
    endtask

    logic p_req = 1'b0;
    logic p_vld = 1'b0;
    logic p_trap = 1'b0;

    always @(negedge clk) begin
        if (bus.o_imem_req && !p_req) mon_event(EV_REQ);
        if (bus.o_instr_valid && !p_vld) mon_event(EV_ISSUE);
        if (bus.o_trap && !p_trap) mon_event(EV_TRAP);
        p_req  <= bus.o_imem_req;
        p_vld  <= bus.o_instr_valid;
        p_trap <= bus.o_trap;
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("reset_req", bus.o_imem_req == 1'b0, $sformatf("req=%b, expected 0", bus.o_imem_req));
        check("reset_state",
              bus.o_pc == RESET_PC && bus.o_pc_four == RESET_PC + 32'd4 &&
              bus.o_instr == 32'h0000_0013 && !bus.o_instr_valid && !bus.o_trap &&
              bus.o_trap_cause == 2'b00 && bus.o_instret == 32'd0,
              $sformatf("pc=%h pc4=%h instr=%h vld=%b trap=%b cause=%b instret=%0d, expected %h %h 00000013 0 0 00 0",
                        bus.o_pc, bus.o_pc_four, bus.o_instr, bus.o_instr_valid, bus.o_trap,
                        bus.o_trap_cause, bus.o_instret, RESET_PC, RESET_PC + 32'd4));
        m_pc = RESET_PC; m_instret = 32'd0; m_instr = 32'h0000_0013; m_trap = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("boot_no_req", bus.o_imem_req == 1'b0, $sformatf("req=%b in boot, expected 0", bus.o_imem_req));
        expect_ev(EV_REQ, 2'b00);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!bus.o_imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.o_imem_req;
        if (!ok) check("req_wait", 1'b0, "req=0 after 20 cycles, expected 1");
    endtask

    task automatic fetch(input logic [31:0] word, input int delay);
        bit ok;
        if (m_trap) return;
        wait_req(ok);
        if (!ok) return;
        if (delay >= T_OUT) expect_ev(EV_TRAP, 2'b10);
        else begin
            m_instr = word;
            expect_ev(EV_ISSUE, 2'b00);
        end
        repeat (delay) begin
            bus.i_imem_rdata = $urandom;
            bus.i_retire     = ($urandom_range(0, 1) == 1);
            bus.i_inst_valid = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        bus.i_retire = 1'b0;
        if (delay < T_OUT)
            check("ack_addr", bus.o_imem_req && bus.o_imem_addr == m_pc,
                  $sformatf("req=%b addr=%h, expected 1 %h", bus.o_imem_req, bus.o_imem_addr, m_pc));
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = word;
        @(posedge clk); #1;
        bus.i_imem_ack   = 1'b0;
        bus.i_imem_rdata = $urandom;
        if (delay >= T_OUT) m_trap = 1'b1;
        else check("ack_latency", bus.o_instr_valid && bus.o_instr == word,
                   $sformatf("vld=%b instr=%h, expected 1 %h", bus.o_instr_valid, bus.o_instr, word));
    endtask

    task automatic retire(input bit iv, input bit sel, input logic [31:0] tgt);
        logic [31:0] npc;
        int w;
        if (m_trap) return;
        w = $urandom_range(0, 3);
        repeat (w) begin
            bus.i_pc_sel     = ($urandom_range(0, 1) == 1);
            bus.i_jmp_target = $urandom;
            bus.i_inst_valid = ($urandom_range(0, 1) == 1);
            bus.i_imem_ack   = ($urandom_range(0, 1) == 1);
            bus.i_imem_rdata = $urandom;
            @(posedge clk); #1;
        end
        bus.i_imem_ack = 1'b0;
        check("issue_hold", bus.o_instr_valid && bus.o_instr == m_instr && bus.o_pc == m_pc,
              $sformatf("vld=%b instr=%h pc=%h, expected 1 %h %h",
                        bus.o_instr_valid, bus.o_instr, bus.o_pc, m_instr, m_pc));
        bus.i_retire = 1'b1; bus.i_inst_valid = iv; bus.i_pc_sel = sel; bus.i_jmp_target = tgt;
        npc = sel ? tgt - (tgt % 2) : m_pc + 32'd4;
        if (!iv) begin
            expect_ev(EV_TRAP, 2'b11);
            m_trap = 1'b1;
        end else if (npc % 4 != 0) begin
            expect_ev(EV_TRAP, 2'b01);
            m_trap = 1'b1;
        end else begin
            m_pc = npc;
            m_instret = m_instret + 32'd1;
            expect_ev(EV_REQ, 2'b00);
        end
        @(posedge clk); #1;
        bus.i_retire     = 1'b0;
        bus.i_pc_sel     = ($urandom_range(0, 1) == 1);
        bus.i_jmp_target = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2000000, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        logic [31:0] tgt;
        bus.i_imem_ack = 1'b0; bus.i_imem_rdata = '0; bus.i_inst_valid = 1'b0;
        bus.i_pc_sel = 1'b0; bus.i_jmp_target = '0; bus.i_retire = 1'b0;

        do_reset();
        fetch(32'h0050_0093, 2);
        retire(1'b1, 1'b0, 32'h0);
        fetch($urandom, 1);
        retire(1'b1, 1'b1, 32'h0000_0101);
        fetch(32'h0000_0013, 0);
        retire(1'b1, 1'b1, 32'hFFFF_FFFC);
        fetch($urandom, 0);
        retire(1'b1, 1'b0, 32'h0);
        fetch($urandom, 3);
        retire(1'b1, 1'b1, 32'h0000_0106);
        repeat (10) @(posedge clk);
        #1 check("trap_hold", bus.o_trap && bus.o_trap_cause == 2'b01 && !bus.o_imem_req && bus.o_pc == m_pc,
                 $sformatf("trap=%b cause=%b req=%b pc=%h, expected 1 01 0 %h",
                           bus.o_trap, bus.o_trap_cause, bus.o_imem_req, bus.o_pc, m_pc));

        do_reset();
        fetch($urandom, T_OUT - 1);
        retire(1'b1, 1'b0, 32'h0);
        fetch($urandom, T_OUT);

        do_reset();
        fetch($urandom, 0);
        retire(1'b0, ($urandom_range(0, 1) == 1), $urandom);

        do_reset();
        wait_req(ok);
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 60; i++) begin
            if (m_trap || $urandom_range(0, 15) == 0) do_reset();
            fetch($urandom, $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) tgt = $urandom;
            else tgt = ($urandom & ~32'd3) | 32'($urandom_range(0, 1));
            retire($urandom_range(0, 9) != 0, ($urandom_range(0, 1) == 1), tgt);
        end

        repeat (5) @(posedge clk);
        #1 check("scoreboard_drained", sb.size() == 0,
                 $sformatf("%0d events outstanding, expected 0", sb.size()));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
